// File: rtl/shift_seq8_pkg.sv
// Shared definitions for the shift_seq8 sequencer and its LSR8 stage.
//   WIDTH    : data width (only 8 is supported, matching LSR8)
//   SHAMT_W  : width of the requested total shift amount (0..7)
//   STEP_MAX : largest shift applied in one cycle (limited by LSR8's 2-bit shamt)
//   STEP_W   : width of the per-cycle step fed to LSR8
//   state_e  : sequencer states IDLE / SHIFT / DONE
package shift_seq8_pkg;

    localparam int WIDTH    = 8;
    localparam int SHAMT_W  = 3;
    localparam int STEP_MAX = 3;
    localparam int STEP_W   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_seq8_lsr8.sv
// LSR8: combinational 8-bit logical right shift by 0..3.
// Ports:
//   d_i     in  WIDTH   operand
//   shamt_i in  STEP_W  shift amount (0..3)
//   d_o     out WIDTH   d_i shifted right, zeros filled from the MSB
module shift_seq8_lsr8
    import shift_seq8_pkg::*;
(
    input  logic [WIDTH-1:0]  d_i,
    input  logic [STEP_W-1:0] shamt_i,
    output logic [WIDTH-1:0]  d_o
);

    assign d_o = d_i >> shamt_i;

endmodule

// File: rtl/shift_seq8.sv
// shift_seq8: multi-cycle 8-bit logical right shifter (shift by 0..7) built
// around the 2-bit LSR8 stage. One operand is accepted per request; the
// running result is shifted by at most 3 bits per cycle and done pulses
// for one cycle when the final value is on d_out_o.
// Ports:
//   clk_i    in  1        rising-edge clock
//   reset_i  in  1        synchronous active-high reset (wins over start)
//   start_i  in  1        request; only looked at while not busy
//   d_in_i   in  WIDTH    operand, captured with an accepted start
//   shamt_i  in  SHAMT_W  total shift amount, captured with an accepted start
//   busy_o   out 1        high while shifting; start is ignored then
//   done_o   out 1        one-cycle pulse, d_out_o final in this cycle
//   d_out_o  out WIDTH    running/final result; holds until next accepted start
//   state_o  out state_e  current FSM state (debug visibility)
// Optional feature, macro SHIFT_SEQ_STATUS_EN adds:
//   zero_o   out 1        final result is zero (valid from done until next start)
//   sticky_o out 1        some 1 bit was shifted out (valid from done until next start)
//
// Handshake: a request is taken on a rising edge where start_i=1 and the
// block is in IDLE or DONE (busy_o=0); d_in_i/shamt_i are captured on that
// same edge. There is no backpressure on the result: done_o is a single-cycle
// pulse and d_out_o keeps the result until the next accepted request.
module shift_seq8
    import shift_seq8_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   d_in_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   d_out_o,
`ifdef SHIFT_SEQ_STATUS_EN
    output logic               zero_o,
    output logic               sticky_o,
`endif
    output state_e             state_o
);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [SHAMT_W-1:0]   rem_q, rem_d;
    logic [STEP_W-1:0]    step;
    logic [WIDTH-1:0]     lsr_out;
    logic                 accept;

    // Per-cycle step: min(rem, STEP_MAX).
    assign step = (rem_q > SHAMT_W'(STEP_MAX)) ? STEP_W'(STEP_MAX) : rem_q[STEP_W-1:0];

    shift_seq8_lsr8 u_lsr8 (
        .d_i     (acc_q),
        .shamt_i (step),
        .d_o     (lsr_out)
    );

    // A request is taken in IDLE or DONE; DONE accepts too, so back-to-back
    // operations need no idle bubble.
    assign accept = start_i && (state_q != SHIFT);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    acc_d   = d_in_i;
                    rem_d   = shamt_i;
                    state_d = (shamt_i != '0) ? SHIFT : DONE;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                acc_d   = lsr_out;
                rem_d   = rem_q - SHAMT_W'(step);
                state_d = (rem_q == SHAMT_W'(step)) ? DONE : SHIFT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
        end
    end

    assign busy_o  = (state_q == SHIFT);
    assign done_o  = (state_q == DONE);
    assign d_out_o = acc_q;
    assign state_o = state_q;

`ifdef SHIFT_SEQ_STATUS_EN
    logic             zero_q, zero_d;
    logic             sticky_q, sticky_d;
    logic [WIDTH-1:0] lost_mask;

    // Bits of acc that fall off the LSB end in this SHIFT step.
    assign lost_mask = ~({WIDTH{1'b1}} << step);

    always_comb begin
        zero_d   = zero_q;
        sticky_d = sticky_q;
        if (accept) begin
            // A zero-length shift goes straight to DONE, so its zero flag
            // must be known at capture time.
            zero_d   = (shamt_i == '0) && (d_in_i == '0);
            sticky_d = 1'b0;
        end else if (state_q == SHIFT) begin
            sticky_d = sticky_q | (|(acc_q & lost_mask));
            if (rem_q == SHAMT_W'(step)) begin
                zero_d = (lsr_out == '0);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            zero_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            zero_q   <= zero_d;
            sticky_q <= sticky_d;
        end
    end

    assign zero_o   = zero_q;
    assign sticky_o = sticky_q;
`endif

endmodule

// File: tb/tb_shift_seq8.sv
// Testbench for shift_seq8: directed cases with hand-computed results plus a
// randomized phase, all checked each cycle against a transaction-level model.
module tb_shift_seq8;
    import shift_seq8_pkg::*;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] d_in;
    logic [2:0] shamt;
    logic       busy;
    logic       done;
    logic [7:0] d_out;
    state_e     state;
`ifdef SHIFT_SEQ_STATUS_EN
    logic       zero;
    logic       sticky;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    shift_seq8 dut (
        .clk_i    (clk),
        .reset_i  (reset),
        .start_i  (start),
        .d_in_i   (d_in),
        .shamt_i  (shamt),
        .busy_o   (busy),
        .done_o   (done),
        .d_out_o  (d_out),
`ifdef SHIFT_SEQ_STATUS_EN
        .zero_o   (zero),
        .sticky_o (sticky),
`endif
        .state_o  (state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // One operation = (din, sh). j counts completed 3-bit steps since the
    // operation started; after j steps the value is din >> min(3j, sh),
    // the block is busy while 3j < sh, and the done cycle is when 3j >= sh.
    int       m_active;
    int       m_j;
    int       m_din;
    int       m_sh;
    int       m_zero;
    int       m_sticky;
    int       model_on = 0;

    always @(posedge clk) begin
        int m_busy_now;
        m_busy_now = m_active && (3 * m_j < m_sh);
        if (reset) begin
            m_active = 0;
            m_j      = 0;
            m_din    = 0;
            m_sh     = 0;
            m_zero   = 0;
            m_sticky = 0;
        end else if (start && !m_busy_now) begin
            m_active = 1;
            m_j      = 0;
            m_din    = int'(d_in);
            m_sh     = int'(shamt);
            m_zero   = ((m_din >> m_sh) == 0);
            m_sticky = ((m_din & ((1 << m_sh) - 1)) != 0);
        end else if (m_active) begin
            if (3 * m_j >= m_sh) m_active = 0;
            else                 m_j = m_j + 1;
        end
        model_on = 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        int e_busy, e_done, e_dout, sh_now;
        if (model_on) begin
            e_busy = m_active && (3 * m_j < m_sh);
            e_done = m_active && !(3 * m_j < m_sh);
            sh_now = (m_active && (3 * m_j < m_sh)) ? 3 * m_j : m_sh;
            e_dout = (m_din >> sh_now) & 8'hFF;
            chk("busy", int'(busy), e_busy);
            chk("done", int'(done), e_done);
            chk("d_out", int'(d_out), e_dout);
`ifdef SHIFT_SEQ_STATUS_EN
            if (!e_busy) begin
                chk("zero", int'(zero), m_zero);
                chk("sticky", int'(sticky), m_sticky);
            end
`endif
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a negedge: presents a request for the next rising
    // edge and returns at the negedge of the first cycle after acceptance.
    task automatic do_start(input logic [7:0] din, input logic [2:0] sh);
        start = 1'b1;
        d_in  = din;
        shamt = sh;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge of the done cycle (or after the bound expires).
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 10) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got done=0 expected done=1 within 10 cycles");
        end
    endtask

    task automatic run_check(input string name, input logic [7:0] din, input logic [2:0] sh,
                             input int exp_dout, input int exp_lat, input int exp_busy,
                             input int exp_zero, input int exp_sticky);
        int lat, bc;
        do_start(din, sh);
        wait_done(lat, bc);
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_busy_cycles"}, bc, exp_busy);
        chk({name, "_d_out"}, int'(d_out), exp_dout);
`ifdef SHIFT_SEQ_STATUS_EN
        chk({name, "_zero"}, int'(zero), exp_zero);
        chk({name, "_sticky"}, int'(sticky), exp_sticky);
`else
        if (exp_zero < 0 || exp_sticky < 0) $display("negative status expectation in %s", name);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, bc, seen_done;
        reset = 1'b1;
        start = 1'b0;
        d_in  = 8'h00;
        shamt = 3'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_d_out", int'(d_out), 0);
        chk("reset_wins_over_start", int'(busy), 0);
        start = 1'b1;
        d_in  = 8'hAA;
        shamt = 3'd4;
        @(negedge clk);
        chk("reset_with_start_busy", int'(busy), 0);
        chk("reset_with_start_d_out", int'(d_out), 0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // 1: steps 3 then 2
        run_check("t1", 8'hB5, 3'd5, 8'h05, 3, 2, 0, 1);
        // 5: back-to-back request in the done cycle
        run_check("t5", 8'h08, 3'd3, 8'h01, 2, 1, 0, 0);
        @(negedge clk);
        // 2: zero-length shift
        run_check("t2", 8'h3C, 3'd0, 8'h3C, 1, 0, 0, 0);
        @(negedge clk);
        // 3: longest shift, steps 3,3,1
        run_check("t3", 8'h80, 3'd7, 8'h01, 4, 3, 0, 0);
        @(negedge clk);

        // 4: a request while busy is ignored
        do_start(8'hFF, 3'd6);
        start = 1'b1;
        d_in  = 8'h00;
        shamt = 3'd1;
        wait_done(lat, bc);
        start = 1'b0;
        chk("t4_latency", lat, 3);
        chk("t4_d_out", int'(d_out), 8'h03);
        @(negedge clk);
        chk("t4_idle_after", int'(done), 0);

        // 6: reset in the second SHIFT cycle aborts the operation
        do_start(8'h80, 3'd7);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_busy", int'(busy), 0);
        chk("t6_done", int'(done), 0);
        chk("t6_d_out", int'(d_out), 0);
        seen_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        chk("t6_no_done_pulse", seen_done, 0);
        run_check("t6_restart", 8'hC3, 3'd2, 8'h30, 2, 1, 0, 1);
        @(negedge clk);

        // Randomized phase: random requests (including ones while busy and
        // back-to-back ones), occasional resets.
        for (int i = 0; i < 2000; i++) begin
            start = ($urandom_range(0, 2) == 0);
            d_in  = 8'($urandom_range(0, 255));
            shamt = 3'($urandom_range(0, 7));
            reset = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        reset = 1'b0;
        repeat (6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
